// File: rtl/box_count_reader.sv
// box_count_reader: drives a per-box point accumulator from the LiDAR point
// stream, reads and clears it at each frame end, and applies a two-threshold,
// multi-frame hysteresis. Each frame produces one detection record, which is
// offered downstream over a valid/ready handshake.
module box_count_reader #(
    parameter int CNT_W     = 4,
    parameter int THR_ON    = 6,
    parameter int THR_OFF   = 3,
    parameter int FRAMES_ON = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pt_valid,
    input  logic             pt_in_box,
    input  logic             frame_end,
    input  logic [CNT_W-1:0] acc_count,
    output logic             acc_ce,
    output logic             acc_inc,
    output logic             acc_clr,
    output logic             det_valid,
    input  logic             det_ready,
    output logic             det_flag,
    output logic [CNT_W-1:0] det_count,
    output logic [7:0]       det_frame,
    output logic             sat,
    output logic             drop_err,
    output logic             ovr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THR_ON_C  = CNT_W'(THR_ON);
    localparam logic [CNT_W-1:0] THR_OFF_C = CNT_W'(THR_OFF);
    localparam logic [3:0]       FR_ON_C   = 4'(FRAMES_ON);

    typedef enum logic [1:0] {ACCUM, SETTLE, CAPTURE} state_t;

    state_t     state, state_nxt;
    logic [3:0] run;        // consecutive hit frames, saturating at 15
    logic       hyst;       // detection state after hysteresis
    logic       sat_flag;   // an increment was suppressed at max this frame
    logic [7:0] frame_idx;

    logic       pt_hit, at_max, hit, accept, hyst_nxt;
    logic [3:0] run_nxt;

    assign pt_hit  = pt_valid & pt_in_box;
    assign at_max  = (acc_count == CNT_MAX);
    assign hit     = (acc_count >= THR_ON_C);
    // The record slot is free if empty or being drained this very cycle.
    assign accept  = ~det_valid | det_ready;
    assign run_nxt = hit ? ((run == 4'hF) ? run : run + 4'd1) : 4'd0;
    // Assertion takes priority over release; otherwise the state holds.
    assign hyst_nxt = (run_nxt >= FR_ON_C)    ? 1'b1 :
                      (acc_count < THR_OFF_C) ? 1'b0 : hyst;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCUM;
        else      state <= state_nxt;
    end

    // Next-state logic: SETTLE covers the one-cycle lag of acc_count behind acc_ce
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (frame_end) state_nxt = SETTLE;
            SETTLE:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulator controls; clear is held during reset and pulsed in CAPTURE
    always_comb begin
        acc_ce  = rst & (state == ACCUM) & pt_hit & ~at_max;
        acc_inc = acc_ce;
        acc_clr = ~rst | (state == CAPTURE);
    end

    // Hysteresis state, frame index and per-frame saturation tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= '0;
            hyst      <= 1'b0;
            frame_idx <= '0;
            sat_flag  <= 1'b0;
        end else if (state == CAPTURE) begin
            run       <= run_nxt;
            hyst      <= hyst_nxt;
            frame_idx <= frame_idx + 8'd1;
            sat_flag  <= 1'b0;
        end else if (state == ACCUM && pt_hit && at_max) begin
            sat_flag  <= 1'b1;
        end
    end

    // Output record: loaded in CAPTURE when the slot is free, else held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_valid <= 1'b0;
            det_flag  <= 1'b0;
            det_count <= '0;
            det_frame <= '0;
            sat       <= 1'b0;
        end else begin
            if (det_valid && det_ready) det_valid <= 1'b0;
            if (state == CAPTURE && accept) begin
                det_valid <= 1'b1;
                det_count <= acc_count;
                det_flag  <= hyst_nxt;
                det_frame <= frame_idx;
                sat       <= sat_flag;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_err <= 1'b0;
            ovr_err  <= 1'b0;
        end else begin
            if (state != ACCUM && (pt_hit || frame_end)) drop_err <= 1'b1;
            if (state == CAPTURE && !accept)             ovr_err  <= 1'b1;
        end
    end

endmodule

// File: doc/box_count_reader.md
Name: box_count_reader

Overview:
- Consumer end of the per-box point accumulator. It drives the accumulator's enable, increment and clear inputs from the LiDAR point stream.
- At each frame end it waits for the accumulator to settle, then reads the count and clears the accumulator.
- It applies a two-threshold, multi-frame hysteresis to the count and reports a per-frame detection record downstream over a valid/ready handshake.

Parameters:
- CNT_W, 4: width of the accumulator count.
- THR_ON, 6: count at or above which a frame is a "hit".
- THR_OFF, 3: count below which an asserted detection is dropped.
- FRAMES_ON, 2: number of consecutive hit frames needed to assert the detection (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pt_valid  in  1  a point is present this cycle.
- pt_in_box  in  1  the point lies inside the box; qualified by pt_valid.
- frame_end  in  1  single-cycle pulse marking the last cycle of a frame.
- acc_count  in  CNT_W  accumulator output (registered count).
- acc_ce  out  1  accumulator clock enable.
- acc_inc  out  1  accumulator A input.
- acc_clr  out  1  active-high clear, wired to the accumulator's rst.
- det_valid  out  1  detection record available.
- det_ready  in  1  downstream accepts the record.
- det_flag  out  1  detection state after hysteresis.
- det_count  out  CNT_W  captured count for the frame.
- det_frame  out  8  frame index of the record.
- sat  out  1  the count reached its maximum in this record's frame.
- drop_err  out  1  sticky: a point arrived outside ACCUM.
- ovr_err  out  1  sticky: a capture happened while det_valid was pending.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = ACCUM.
  - All registers cleared, including the hysteresis run counter and the frame index.
  - det_valid, det_flag, det_count, det_frame, sat, drop_err and ovr_err are all 0.
  - acc_clr = 1 while rst=0; acc_ce = 0 and acc_inc = 0.
- FSM states: ACCUM, SETTLE, CAPTURE.
- ACCUM:
  - acc_ce = acc_inc = pt_valid & pt_in_box & (acc_count != 2^CNT_W-1). These outputs are combinational.
  - Saturation: if pt_valid & pt_in_box while acc_count == max, the increment is suppressed (no wrap) and the internal saturation flag is set.
  - On frame_end=1, go to SETTLE. A point in the same cycle as frame_end is still counted.
- SETTLE:
  - Exactly one cycle, needed because acc_count lags acc_ce by one cycle.
  - acc_ce = 0. Next state CAPTURE.
- CAPTURE:
  - One cycle. acc_clr = 1 and acc_ce = 0.
  - Count c = acc_count. A hit is c >= THR_ON.
  - Run counter: on a hit, run = min(run+1, 15); otherwise run = 0.
  - Flag: becomes 1 when the new run >= FRAMES_ON. Becomes 0 when c < THR_OFF. Holds in every other case.
  - Record update when det_valid=0, or det_valid=1 with det_ready=1 this cycle:
    - load det_count = c, det_flag, det_frame = frame index, sat = saturation flag;
    - set det_valid = 1.
  - Record update when det_valid=1 and det_ready=0:
    - the record is not overwritten and ovr_err is set;
    - the hysteresis state and the frame index still advance.
  - Frame index increments modulo 256. The saturation flag clears.
  - Next state ACCUM.
- Points arriving with pt_valid & pt_in_box in SETTLE or CAPTURE are not counted and set drop_err.
- frame_end in SETTLE or CAPTURE is ignored and sets drop_err.
- Handshake:
  - det_valid falls on the cycle after det_valid & det_ready, unless a CAPTURE reloads the record in that same cycle.
  - Record outputs are stable while det_valid=1 and det_ready=0.
- Latency: frame_end at cycle t gives det_valid=1 at t+3 (state SETTLE at t+1, CAPTURE at t+2, record registered).
- Sticky errors clear only on reset.
- Reset mid-frame discards the partial frame; the accumulator is cleared via acc_clr.

Test Plan:
- Frame 1 with 7 in-box points out of 10, then frame_end; det_ready=1 -> det_valid at t+3, det_count=7, det_flag=0 (run=1), det_frame=0. Frame 2 with 7 points -> det_flag=1, det_frame=1.
- Flag asserted, then frames with counts 4 and 2 -> flag stays 1 at count 4, becomes 0 at count 2. A frame with count 9 after that -> flag stays 0 (run=1).
- 20 in-box points in consecutive cycles -> acc_inc stops once acc_count=15, det_count=15, sat=1. Next frame with 3 points -> sat=0, det_count=3.
- Point on the frame_end cycle counted; points in SETTLE or CAPTURE not counted -> drop_err=1. Count check: 5 in ACCUM plus 1 on frame_end -> det_count=6.
- det_ready held 0 across two frame ends -> first record retained, ovr_err=1, det_frame of the held record=0. det_ready=1 at the next capture -> record shows det_frame=2.
- rst pulsed low in mid-frame with det_valid=1 -> all outputs 0, acc_clr=1 during reset. The next frame reports det_frame=0.
